// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcode values, opcode classes and sequencer state encoding
package alu_ctrl_pkg;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHRA = 5'h08;
  localparam logic [4:0] OP_SHL  = 5'h09;
  localparam logic [4:0] OP_ROR  = 5'h0a;
  localparam logic [4:0] OP_ROL  = 5'h0b;
  localparam logic [4:0] OP_MUL  = 5'h0f;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NEG  = 5'h11;
  localparam logic [4:0] OP_NOT  = 5'h12;
  typedef enum logic [1:0] {CLS_BIN, CLS_UNA, CLS_MD, CLS_ILL} op_class_t;
  typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_EXEC, S_WBLO, S_WBHI, S_ERR} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode -> operation class
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] op,
  output op_class_t      cls
);
  always_comb
    cls = (op inside {OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR)}) ? CLS_BIN
        : (op inside {OPW'(OP_SHR), OPW'(OP_SHRA), OPW'(OP_SHL), OPW'(OP_ROR),
                      OPW'(OP_ROL), OPW'(OP_NEG), OPW'(OP_NOT)}) ? CLS_UNA
        : (op inside {OPW'(OP_MUL), OPW'(OP_DIV)}) ? CLS_MD
        : CLS_ILL;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle execute-phase control FSM for register-to-register ALU ops
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OPW   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [OPW-1:0]   opcode,
  output logic             ready,
  output logic             RaOut,
  output logic             RbOut,
  output logic             Yin,
  output logic             ALUin,
  output logic [OPW-1:0]   ALUControl,
  output logic             Zin,
  output logic             ZLoOut,
  output logic             ZHiOut,
  output logic             RzIn,
  output logic             LOin,
  output logic             HIin,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);
  state_t         state;
  op_class_t      in_cls;
  op_class_t      cls;
  logic [OPW-1:0] op;
  logic           two_op;
  logic           md;
  alu_op_decode #(.OPW(OPW)) u_dec (
    .op  (opcode),
    .cls (in_cls)
  );
  assign two_op = (cls == CLS_BIN) || (cls == CLS_MD);
  assign md     = cls == CLS_MD;
  // Outputs are loaded for the state being entered, so every strobe is a clean register output
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      state      <= S_IDLE;
      cls        <= CLS_BIN;
      op         <= '0;
      ready      <= 1'b1;
      {RaOut, RbOut, Yin, ALUin, Zin, ZLoOut, ZHiOut, RzIn, LOin, HIin, done, illegal} <= '0;
      ALUControl <= '0;
      op_count   <= '0;
    end else begin
      {RaOut, RbOut, Yin, ALUin, Zin, ZLoOut, ZHiOut, RzIn, LOin, HIin, done, illegal} <= '0;
      ready <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            op      <= opcode;
            cls     <= in_cls;
            state   <= (in_cls == CLS_ILL) ? S_ERR : S_LDA;
            done    <= in_cls == CLS_ILL;
            illegal <= in_cls == CLS_ILL;
            RaOut   <= in_cls != CLS_ILL;
            Yin     <= in_cls != CLS_ILL;
          end else
            ready <= 1'b1;
        S_LDA: begin
          state      <= S_LDB;
          ALUControl <= op;
          RbOut      <= two_op;
        end
        S_LDB: begin
          state <= S_EXEC;
          RbOut <= two_op;
          ALUin <= 1'b1;
          Zin   <= 1'b1;
        end
        S_EXEC: begin
          state  <= md ? S_WBHI : S_WBLO;
          ZLoOut <= 1'b1;
          RzIn   <= !md;
          LOin   <= md;
          done   <= !md;
          if (!md) op_count <= op_count + 1'b1;
        end
        S_WBHI: begin
          state    <= S_WBLO;
          ZHiOut   <= 1'b1;
          HIin     <= 1'b1;
          done     <= 1'b1;
          op_count <= op_count + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random stimulus against a per-cycle strobe schedule model
module tb_alu_op_sequencer;
  typedef struct packed {
    logic ready, ra, rb, yin, aluin, zin, zlo, zhi, rzin, loin, hiin, done, illegal;
  } ov_t;
  typedef struct packed {
    ov_t        v;
    logic       setctl;
    logic [4:0] ctl;
    logic       cnt;
  } ent_t;
  localparam ov_t IDLE_V = 13'h1000;
  logic clock, clear_n, start;
  logic [4:0] opcode;
  logic ready, RaOut, RbOut, Yin, ALUin, Zin, ZLoOut, ZHiOut, RzIn, LOin, HIin, done, illegal;
  logic [4:0] ALUControl;
  logic [15:0] op_count;
  logic [12:0] w_misc;
  logic [4:0] w_ctl;
  logic [1:0] w_cnt;
  ov_t obs;
  ent_t q[$];
  logic [4:0] exp_ctl;
  logic [15:0] exp_cnt;
  int cmp = 0, bad = 0;
  logic [4:0] legal [13] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                             5'h0a, 5'h0b, 5'h0f, 5'h10, 5'h11, 5'h12};
  alu_op_sequencer dut (
    .clock(clock), .clear_n(clear_n), .start(start), .opcode(opcode), .ready(ready),
    .RaOut(RaOut), .RbOut(RbOut), .Yin(Yin), .ALUin(ALUin), .ALUControl(ALUControl),
    .Zin(Zin), .ZLoOut(ZLoOut), .ZHiOut(ZHiOut), .RzIn(RzIn), .LOin(LOin), .HIin(HIin),
    .done(done), .illegal(illegal), .op_count(op_count)
  );
  // Narrow-counter copy makes the counter wrap reachable in a short run
  alu_op_sequencer #(.CNT_W(2)) dut_w (
    .clock(clock), .clear_n(clear_n), .start(start), .opcode(opcode), .ready(w_misc[12]),
    .RaOut(w_misc[11]), .RbOut(w_misc[10]), .Yin(w_misc[9]), .ALUin(w_misc[8]),
    .ALUControl(w_ctl), .Zin(w_misc[7]), .ZLoOut(w_misc[6]), .ZHiOut(w_misc[5]),
    .RzIn(w_misc[4]), .LOin(w_misc[3]), .HIin(w_misc[2]), .done(w_misc[1]),
    .illegal(w_misc[0]), .op_count(w_cnt)
  );
  assign obs = {ready, RaOut, RbOut, Yin, ALUin, Zin, ZLoOut, ZHiOut, RzIn, LOin, HIin, done, illegal};
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, got, exp);
    end
  endtask
  // 0=two-operand, 1=unary, 2=mul/div, 3=unsupported
  function automatic int cls_of(input logic [4:0] o);
    case (o)
      5'h03, 5'h04, 5'h05, 5'h06: return 0;
      5'h07, 5'h08, 5'h09, 5'h0a, 5'h0b, 5'h11, 5'h12: return 1;
      5'h0f, 5'h10: return 2;
      default: return 3;
    endcase
  endfunction
  function automatic void push_op(input logic [4:0] o);
    int c = cls_of(o);
    ent_t x;
    x = '0;
    if (c == 3) begin
      x.v.done = 1'b1;
      x.v.illegal = 1'b1;
      q.push_back(x);
      return;
    end
    x.v.ra = 1'b1;
    x.v.yin = 1'b1;
    q.push_back(x);
    x = '0;
    x.v.rb = c != 1;
    x.setctl = 1'b1;
    x.ctl = o;
    q.push_back(x);
    x = '0;
    x.v.rb = c != 1;
    x.v.aluin = 1'b1;
    x.v.zin = 1'b1;
    q.push_back(x);
    x = '0;
    x.v.zlo = 1'b1;
    x.v.rzin = c != 2;
    x.v.loin = c == 2;
    x.v.done = c != 2;
    x.cnt = c != 2;
    q.push_back(x);
    if (c == 2) begin
      x = '0;
      x.v.zhi = 1'b1;
      x.v.hiin = 1'b1;
      x.v.done = 1'b1;
      x.cnt = 1'b1;
      q.push_back(x);
    end
  endfunction
  task automatic cyc(input logic st, input logic [4:0] opc);
    ov_t e;
    ent_t x;
    @(negedge clock);
    e = IDLE_V;
    if (q.size() != 0) begin
      x = q.pop_front();
      e = x.v;
      if (x.setctl) exp_ctl = x.ctl;
      if (x.cnt) exp_cnt = exp_cnt + 16'd1;
    end
    chk("outputs", obs, e);
    chk("outputs_w", w_misc, e);
    chk("alucontrol", ALUControl, exp_ctl);
    chk("op_count", op_count, exp_cnt);
    chk("op_count_wrap", w_cnt, exp_cnt[1:0]);
    chk("bus_onehot", 32'($countones({RaOut, RbOut, ZLoOut, ZHiOut}) <= 1), 1);
    start = st;
    opcode = opc;
    if (e.ready && st) push_op(opc);
  endtask
  task automatic do_reset();
    #1 clear_n = 1'b0;
    #1;
    chk("rst_outputs", obs, IDLE_V);
    chk("rst_outputs_w", w_misc, IDLE_V);
    chk("rst_alucontrol", ALUControl, 0);
    chk("rst_op_count", op_count, 0);
    q.delete();
    exp_ctl = '0;
    exp_cnt = '0;
    start = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
  endtask
  initial begin
    clear_n = 1'b1;
    start = 1'b0;
    opcode = '0;
    exp_ctl = '0;
    exp_cnt = '0;
    do_reset();
    cyc(1'b1, 5'h03);
    repeat (3) cyc(1'b0, 5'h00);
    do_reset();
    repeat (2) cyc(1'b0, 5'h00);
    cyc(1'b1, 5'h03);
    repeat (6) cyc(1'b0, 5'h1f);
    cyc(1'b1, 5'h0f);
    repeat (7) cyc(1'b0, 5'h03);
    cyc(1'b1, 5'h09);
    repeat (6) cyc(1'b0, 5'h00);
    cyc(1'b1, 5'h12);
    repeat (6) cyc(1'b0, 5'h00);
    cyc(1'b1, 5'h1f);
    repeat (3) cyc(1'b0, 5'h00);
    repeat (15) cyc(1'b1, 5'h03);
    repeat (6) cyc(1'b0, 5'h00);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc(1'($urandom_range(0, 1)),
          $urandom_range(0, 1) ? legal[$urandom_range(0, 12)] : 5'($urandom));
    end
    repeat (8) cyc(1'b0, 5'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
